// File: rtl/median_stream_filter.sv
// rtl/median_stream_filter.sv - streaming 3x3 clamp-replicate median filter with two rotating line buffers
// Define MEDIAN_BORDER_PASS_EN to pass image-border pixels through unfiltered.
module median_stream_filter #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [ADDR_W-1:0] out_address,
  output logic              out_last,
  output logic              busy
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int FW   = $clog2(IMG_W + 1);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int VW   = 9 * PIX_W;
  localparam logic [CW-1:0]     COL_MAX    = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_MAX    = RW'(IMG_H - 1);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(IMG_W);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(NPIX - 1);

  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
    $error("median_stream_filter: IMG_W and IMG_H must be at least 3");
  end
  if ((64'd1 << ADDR_W) < 64'(NPIX)) begin : g_bad_addr
    $error("median_stream_filter: ADDR_W too small for IMG_W*IMG_H");
  end

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic              live;
  logic [CW-1:0]     col_i;
  logic [RW-1:0]     row_i;
  logic [FW-1:0]     fcnt;
  logic [CW-1:0]     cen_col;
  logic [RW-1:0]     cen_row;
  logic [ADDR_W-1:0] cen_addr;
  logic [1:0]        frames;

  logic [PIX_W-1:0]  lb1 [IMG_W];
  logic [PIX_W-1:0]  lb2 [IMG_W];
  logic [PIX_W-1:0]  win [3][3];
  logic [CW-1:0]     rd_col;
  logic [PIX_W-1:0]  lb1_rd, lb2_rd;

  logic              s0_v, s1_v, s2_v, s3_v;
  logic [CW-1:0]     s0_col;
  logic [RW-1:0]     s0_row;
  logic [ADDR_W-1:0] s0_addr, s1_addr, s2_addr, s3_addr;
  logic              s1_last, s2_last, s3_last;
  logic [VW-1:0]     s1_w, s2_w, s3_w;
  logic [VW-1:0]     clamp_w, net_a, net_b, net_c;
  logic [PIX_W-1:0]  med_out;
  logic [1:0]        csel [3];
  logic [1:0]        rsel [3];

  logic adv, accept, flush_step, step, emit, in_last, first_acc, last_xfer;

  assign adv        = !out_valid || out_ready;
  assign in_ready   = live && (state == RUN) && adv;
  assign accept     = in_valid && in_ready;
  assign flush_step = (state == FLUSH) && adv;
  assign step       = accept || flush_step;
  assign in_last    = (row_i == ROW_MAX) && (col_i == COL_MAX);
  assign emit       = flush_step ||
                      (accept && ((row_i > RW'(1)) || ((row_i == RW'(1)) && (col_i != '0))));
  assign first_acc  = accept && (row_i == '0) && (col_i == '0);
  assign last_xfer  = out_valid && out_ready && out_last;
  assign busy       = (frames != 2'd0);

  // Flush steps walk one virtual row past the frame, ending on column 0.
  always_comb begin
    rd_col = col_i;
    if (state == FLUSH) rd_col = (fcnt == FLUSH_LAST) ? '0 : fcnt[CW-1:0];
  end

  assign lb1_rd = lb1[rd_col];
  assign lb2_rd = lb2[rd_col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_i] <= in_pixel;
      lb2[col_i] <= lb1[col_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      live     <= 1'b0;
      col_i    <= '0;
      row_i    <= '0;
      fcnt     <= '0;
      cen_col  <= '0;
      cen_row  <= '0;
      cen_addr <= '0;
      frames   <= '0;
      s0_v     <= 1'b0;
      s0_col   <= '0;
      s0_row   <= '0;
      s0_addr  <= '0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win[c][r] <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        if (col_i == COL_MAX) begin
          col_i <= '0;
          row_i <= (row_i == ROW_MAX) ? '0 : row_i + 1'b1;
        end else begin
          col_i <= col_i + 1'b1;
        end
        if (in_last) state <= FLUSH;
      end
      if (flush_step) begin
        if (fcnt == FLUSH_LAST) begin
          fcnt  <= '0;
          state <= RUN;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      // Column 0 is newest; row 0 is the oldest line (top of the window).
      if (step) begin
        for (int r = 0; r < 3; r++) begin
          win[2][r] <= win[1][r];
          win[1][r] <= win[0][r];
        end
        win[0][0] <= lb2_rd;
        win[0][1] <= lb1_rd;
        win[0][2] <= accept ? in_pixel : '0;
      end
      if (adv) s0_v <= emit;
      if (emit) begin
        s0_col  <= cen_col;
        s0_row  <= cen_row;
        s0_addr <= cen_addr;
        if (cen_addr == ADDR_MAX) begin
          cen_addr <= '0;
          cen_col  <= '0;
          cen_row  <= '0;
        end else begin
          cen_addr <= cen_addr + 1'b1;
          if (cen_col == COL_MAX) begin
            cen_col <= '0;
            cen_row <= cen_row + 1'b1;
          end else begin
            cen_col <= cen_col + 1'b1;
          end
        end
      end
      if (first_acc && !last_xfer) frames <= frames + 2'd1;
      else if (last_xfer && !first_acc) frames <= frames - 2'd1;
    end
  end

  // Edge clamping: out-of-image neighbours reuse the centre column/row.
  always_comb begin
    csel[0] = (s0_col == '0) ? 2'd1 : 2'd2;
    csel[1] = 2'd1;
    csel[2] = (s0_col == COL_MAX) ? 2'd1 : 2'd0;
    rsel[0] = (s0_row == '0) ? 2'd1 : 2'd0;
    rsel[1] = 2'd1;
    rsel[2] = (s0_row == ROW_MAX) ? 2'd1 : 2'd2;
    clamp_w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        clamp_w[(r*3+c)*PIX_W +: PIX_W] = win[csel[c]][rsel[r]];
  end

  function automatic logic [VW-1:0] cx(input logic [VW-1:0] v, input int i, input int j);
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    a  = v[i*PIX_W +: PIX_W];
    b  = v[j*PIX_W +: PIX_W];
    cx = v;
    if (a > b) begin
      cx[i*PIX_W +: PIX_W] = b;
      cx[j*PIX_W +: PIX_W] = a;
    end
  endfunction

  always_comb begin
    net_a = s1_w;
    net_a = cx(net_a, 1, 2); net_a = cx(net_a, 4, 5); net_a = cx(net_a, 7, 8);
    net_a = cx(net_a, 0, 1); net_a = cx(net_a, 3, 4); net_a = cx(net_a, 6, 7);
    net_a = cx(net_a, 1, 2); net_a = cx(net_a, 4, 5); net_a = cx(net_a, 7, 8);
    net_b = s2_w;
    net_b = cx(net_b, 0, 3); net_b = cx(net_b, 5, 8); net_b = cx(net_b, 4, 7);
    net_b = cx(net_b, 3, 6); net_b = cx(net_b, 1, 4); net_b = cx(net_b, 2, 5);
    net_c = s3_w;
    net_c = cx(net_c, 4, 7); net_c = cx(net_c, 4, 2);
    net_c = cx(net_c, 6, 4); net_c = cx(net_c, 4, 2);
  end

`ifdef MEDIAN_BORDER_PASS_EN
  logic             border0;
  logic             s1_bp, s2_bp, s3_bp;
  logic [PIX_W-1:0] s1_cen, s2_cen, s3_cen;

  assign border0 = (s0_row == '0) || (s0_row == ROW_MAX) || (s0_col == '0) || (s0_col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_bp  <= 1'b0;
      s2_bp  <= 1'b0;
      s3_bp  <= 1'b0;
      s1_cen <= '0;
      s2_cen <= '0;
      s3_cen <= '0;
    end else if (adv) begin
      s1_bp  <= border0;
      s2_bp  <= s1_bp;
      s3_bp  <= s2_bp;
      s1_cen <= win[1][1];
      s2_cen <= s1_cen;
      s3_cen <= s2_cen;
    end
  end

  assign med_out = s3_bp ? s3_cen : net_c[4*PIX_W +: PIX_W];
`else
  assign med_out = net_c[4*PIX_W +: PIX_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      s3_v        <= 1'b0;
      s1_w        <= '0;
      s2_w        <= '0;
      s3_w        <= '0;
      s1_addr     <= '0;
      s2_addr     <= '0;
      s3_addr     <= '0;
      s1_last     <= 1'b0;
      s2_last     <= 1'b0;
      s3_last     <= 1'b0;
      out_valid   <= 1'b0;
      out_pixel   <= '0;
      out_address <= '0;
      out_last    <= 1'b0;
    end else if (adv) begin
      s1_v        <= s0_v;
      s1_w        <= clamp_w;
      s1_addr     <= s0_addr;
      s1_last     <= (s0_addr == ADDR_MAX);
      s2_v        <= s1_v;
      s2_w        <= net_a;
      s2_addr     <= s1_addr;
      s2_last     <= s1_last;
      s3_v        <= s2_v;
      s3_w        <= net_b;
      s3_addr     <= s2_addr;
      s3_last     <= s2_last;
      out_valid   <= s3_v;
      out_pixel   <= med_out;
      out_address <= s3_addr;
      out_last    <= s3_v && s3_last;
    end
  end

endmodule

// File: tb/tb_median_stream_filter.sv
// tb/tb_median_stream_filter.sv - directed bench for median_stream_filter on an 8x6 image
module tb_median_stream_filter;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_pixel = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_pixel;
  logic [AW-1:0] out_address;
  logic          out_last;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]    img      [N];
  logic [7:0]    exp_pix  [N];
  logic [7:0]    got_pix  [N];
  logic [AW-1:0] got_addr [N];
  logic          got_last [N];

  always #5 clk = ~clk;

  median_stream_filter #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_address(out_address), .out_last(out_last), .busy(busy)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, got, want);
    end
  endtask

  function automatic logic [7:0] ref_med(int r, int c);
    logic [7:0] v [9];
    logic [7:0] t;
    int k, rr, cc;
    k = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr; cc = c + dc;
        if (rr < 0) rr = 0;
        if (rr > H-1) rr = H-1;
        if (cc < 0) cc = 0;
        if (cc > W-1) cc = W-1;
        v[k] = img[rr*W + cc];
        k++;
      end
    for (int a = 0; a < 9; a++)
      for (int b = 0; b < 8 - a; b++)
        if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
    return v[4];
  endfunction

  function automatic logic [7:0] ref_out(int i);
    int r, c;
    r = i / W; c = i % W;
`ifdef MEDIAN_BORDER_PASS_EN
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return img[i];
`endif
    return ref_med(r, c);
  endfunction

  task automatic feed(input int count, input logic [7:0] value);
    int k, cyc;
    k = 0; cyc = 0;
    while (k < count && cyc < 1000) begin
      @(negedge clk);
      in_valid = 1'b1; in_pixel = value; out_ready = 1'b1;
      #1;
      if (in_ready) k++;
      @(posedge clk); cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("feed_count", 0, k, count);
  endtask

  task automatic run_frame(input string tag, input bit rnd, input bit lat_chk);
    int idx, n, cyc, acc9, first_out;
    bit held, busy_seen;
    logic [7:0] hp;
    logic [AW-1:0] ha;
    logic hl;
    idx = 0; n = 0; cyc = 0; acc9 = -1; first_out = -1; held = 0; busy_seen = 0;
    while (n < N && cyc < 3000) begin
      @(negedge clk);
      if (held) begin
        chk({tag, "_stall_hold"}, n, {out_valid, out_last, out_address, out_pixel}, {1'b1, hl, ha, hp});
      end
      if (idx > 0 && !busy_seen) begin
        busy_seen = 1;
        chk({tag, "_busy_high"}, idx, busy, 1);
      end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid  = (idx < N) && (!rnd || $urandom_range(0, 3) != 0);
      in_pixel  = (idx < N) ? img[idx] : 8'h00;
      #1;
      held = out_valid && !out_ready;
      if (held) begin
        hp = out_pixel; ha = out_address; hl = out_last;
        chk({tag, "_stall_in_ready"}, n, in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        got_pix[n] = out_pixel; got_addr[n] = out_address; got_last[n] = out_last;
        n++;
      end
      if (in_valid && in_ready) begin
        if (idx == W + 1) acc9 = cyc + 1;
        idx++;
      end
      @(posedge clk); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_out_count"}, 0, n, N);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pixel"}, i, got_pix[i], exp_pix[i]);
      chk({tag, "_addr_last"}, i, {got_last[i], got_addr[i]}, {(i == N-1), AW'(i)});
    end
    if (lat_chk) chk({tag, "_latency"}, 0, first_out - acc9, 4);
    @(negedge clk); #1;
    chk({tag, "_busy_low"}, 0, busy, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", 0, out_valid, 0);
    chk("rst_out_pixel", 0, out_pixel, 0);
    chk("rst_out_address", 0, out_address, 0);
    chk("rst_out_last", 0, out_last, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_in_ready", 0, in_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("release_in_ready_before_edge", 0, in_ready, 0);
    @(posedge clk); #1;
    chk("release_in_ready_after_edge", 0, in_ready, 1);

    for (int i = 0; i < N; i++) begin img[i] = 8'h5A; exp_pix[i] = 8'h5A; end
    run_frame("const", 0, 1);

    for (int i = 0; i < N; i++) begin img[i] = 8'h00; exp_pix[i] = 8'h00; end
    img[2*W + 3] = 8'hFF;
    run_frame("impulse", 0, 0);

    for (int i = 0; i < N; i++) begin img[i] = 8'(10 * (i % W)); exp_pix[i] = 8'(10 * (i % W)); end
    run_frame("ramp", 0, 0);

    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) exp_pix[i] = ref_out(i);
    run_frame("random", 1, 0);

    for (int i = 0; i < N; i++) img[i] = (((i / W) + (i % W)) % 2 == 1) ? 8'hFF : 8'h00;
    for (int i = 0; i < N; i++) exp_pix[i] = ref_out(i);
    run_frame("checker", 0, 0);

    feed(20, 8'h77);
    rst_n = 1'b0; #1;
    chk("midrst_in_ready", 0, in_ready, 0);
    chk("midrst_out_valid", 0, out_valid, 0);
    chk("midrst_busy", 0, busy, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin img[i] = 8'h11; exp_pix[i] = 8'h11; end
    run_frame("after_reset", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
